// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 restoring divide sequencer.
// Borrows the shared 16-bit ALU for one shift-add or shift-subtract step per clock.
module alu_muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        dz_o,
  output logic [15:0] res_hi_o,
  output logic [15:0] res_lo_o,
  output logic        alu_own_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic        alu_cin_o,
  output logic [1:0]  alu_s_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_c_i
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] hi_q, lo_q, opnd_q;
  logic        opsel_q, dz_q;

  logic [15:0] shl_hi;
  logic        div_ok;

  // Partial remainder shifted left by one; its 17th bit is hi_q[15].
  assign shl_hi = {hi_q[14:0], lo_q[15]};
  assign div_ok = hi_q[15] | alu_c_i;

  always_comb begin
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_s_o   = 2'b00;
    alu_cin_o = 1'b0;
    if (state_q == StRun) begin
      if (opsel_q) begin
        alu_a_o = shl_hi;
        alu_b_o = opnd_q;
        alu_s_o = 2'b10;
      end else begin
        alu_a_o = hi_q;
        alu_b_o = lo_q[0] ? opnd_q : 16'h0000;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      opsel_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            opsel_q <= op_i;
            if (op_i && (opb_i == 16'h0000)) begin
              hi_q    <= opa_i;
              lo_q    <= 16'hFFFF;
              dz_q    <= 1'b1;
              state_q <= StDone;
            end else begin
              hi_q    <= '0;
              lo_q    <= opa_i;
              opnd_q  <= opb_i;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (opsel_q) begin
            if (div_ok) begin
              hi_q <= alu_result_i;
              lo_q <= {lo_q[14:0], 1'b1};
            end else begin
              hi_q <= shl_hi;
              lo_q <= {lo_q[14:0], 1'b0};
            end
          end else begin
            {hi_q, lo_q} <= {alu_c_i, alu_result_i, lo_q[15:1]};
          end
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = (state_q == StRun);
  assign alu_own_o = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign dz_o      = dz_q;
  assign res_hi_o  = hi_q;
  assign res_lo_o  = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU, vector table, scoreboard queue,
// plus hand-written start-while-busy and mid-operation reset sequences.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op;
  logic [15:0] opa, opb;
  logic        busy, done, dz, alu_own, alu_cin, alu_c;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_result;
  logic [1:0]  alu_s;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .op_i         (op),
    .opa_i        (opa),
    .opb_i        (opb),
    .busy_o       (busy),
    .done_o       (done),
    .dz_o         (dz),
    .res_hi_o     (res_hi),
    .res_lo_o     (res_lo),
    .alu_own_o    (alu_own),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_cin_o    (alu_cin),
    .alu_s_o      (alu_s),
    .alu_result_i (alu_result),
    .alu_c_i      (alu_c)
  );

  // Shared ALU: 00 = A+B+Cin, 10 = A-B with carry meaning no borrow.
  always_comb begin
    if (alu_s == 2'b10) {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
    else                {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
  end

  typedef struct {
    logic        op;
    logic [15:0] a, b;
    logic [15:0] exp_hi, exp_lo;
    logic        exp_dz;
    int          glitch;
  } vec_t;

  typedef struct {
    logic [15:0] hi, lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eh, input logic [15:0] el, input logic edz,
                        input int glitch);
    exp_t e;
    int   n, busy_cnt;
    logic got, drive_bad;
    e.hi = eh; e.lo = el; e.dz = edz;
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 1; busy_cnt = 0; got = 1'b0; drive_bad = 1'b0;
    while (!got && n <= 40) begin
      if (busy) begin
        busy_cnt++;
        if (!alu_own || alu_cin || alu_s != (o ? 2'b10 : 2'b00)) drive_bad = 1'b1;
      end else if (alu_own || alu_a != 0 || alu_b != 0 || alu_s != 0 || alu_cin) begin
        drive_bad = 1'b1;
      end
      if (n == 1 && !edz) begin
        if (o) check("first_step_alu", {alu_a, alu_b}, {15'd0, a[15], b});
        else   check("first_step_alu", {alu_a, alu_b}, {16'd0, (a[0] ? b : 16'd0)});
      end
      start = (n == glitch);
      if (n == glitch) begin
        op = ~o; opa = ~a; opb = b ^ 16'h00FF;
      end
      if (done) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("res_hi", res_hi, e.hi);
          check("res_lo", res_lo, e.lo);
          check("dz", dz, e.dz);
        end
        check("done_latency", n, edz ? 1 : 17);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    check("busy_cycles", busy_cnt, edz ? 0 : 16);
    check("alu_drive", drive_bad, 0);
    @(negedge clk);
    check("single_done", {done, busy}, 0);
    check("result_hold", {res_hi, res_lo}, {eh, el});
  endtask

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    int dcount;
    logic [15:0] ra, rb;
    logic [31:0] prod;

    vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 0};
    vecs[2] = '{1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 0};
    vecs[3] = '{1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0, 0};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 0};
    vecs[5] = '{1'b1, 16'h0005, 16'h8001, 16'h0005, 16'h0000, 1'b0, 0};
    vecs[6] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0};
    vecs[7] = '{1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 0};
    vecs[8] = '{1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 5};
    vecs[9] = '{1'b1, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 1'b0, 5};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    #1;
    check("reset_state", {busy, done, dz, res_hi, res_lo, alu_own, alu_a, alu_b, alu_cin, alu_s},
          '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             vecs[i].exp_dz, vecs[i].glitch);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(1, 255));
      if (i % 3 == 0) begin
        prod = {16'd0, ra} * {16'd0, rb};
        run_op(1'b0, ra, rb, prod[31:16], prod[15:0], 1'b0, 0);
      end else begin
        run_op(1'b1, ra, rb, ra % rb, ra / rb, 1'b0, 0);
      end
    end

    // Mid-operation reset: abort at RUN cycle 8, then a fresh 3 x 5.
    @(negedge clk);
    op = 1'b0; opa = 16'h1234; opb = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_run", {busy, done, dz, res_hi, res_lo, alu_own, alu_a, alu_b, alu_cin, alu_s},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    run_op(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle unsigned 16x16 multiply / 16÷16 divide sequencer. It borrows the CPU's shared 16-bit ALU (A/B/Cin/S in; Result/C out) and performs one shift-add or shift-subtract step per clock. The CPU stalls while the sequencer owns the ALU. It sits beside the ALU, and `alu_own` steers the ALU input mux away from the single-cycle datapath.

## Interface
- No parameters. Width is fixed at 16 to match the ALU.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`
- `opa`  in  16  multiplicand / dividend
- `opb`  in  16  multiplier / divisor
- `busy`  out  1  high while iterating (RUN)
- `done`  out  1  one-cycle pulse; results valid
- `dz`  out  1  divide-by-zero flag, valid with `done`
- `res_hi`  out  16  product[31:16] / remainder
- `res_lo`  out  16  product[15:0] / quotient
- `alu_own`  out  1  ALU input mux select (= `busy`)
- `alu_a`, `alu_b`  out  16  ALU operands
- `alu_cin`  out  1  ALU carry-in
- `alu_s`  out  2  ALU op: 00 = A+B, 10 = A−B
- `alu_result`  in  16  ALU sum
- `alu_c`  in  1  ALU carry-out; 1 on subtract means no borrow

## Operation
- **State registers:** FSM (IDLE, RUN, DONE); `cnt` 4-bit; `hi`, `lo`, `opnd` 16-bit; `opsel`; `dz`.
- **IDLE:**
  - Multiply, or divide with `opb != 0`: on `start`, load `hi` = 0, `lo` = `opa`, `opnd` = `opb`, `cnt` = 0, `dz` = 0, then go to RUN.
  - Divide with `opb == 0`: on `start`, load `hi` = `opa`, `lo` = 0xFFFF, `dz` = 1, then go straight to DONE.
- **RUN, multiply step:**
  - ALU drive: `alu_a` = `hi`; `alu_b` = `lo[0]` ? `opnd` : 0; `alu_s` = 00; `alu_cin` = 0.
  - Update: {`hi`,`lo`} <= {`alu_c`, `alu_result`, `lo[15:1]`}.
- **RUN, divide step (restoring):**
  - ALU drive: `alu_a` = {`hi[14:0]`, `lo[15]`}; `alu_b` = `opnd`; `alu_s` = 10; `alu_cin` = 0.
  - Success condition: `hi[15] | alu_c`. The 17th partial-remainder bit is `hi[15]`.
  - On success: `hi` <= `alu_result`; `lo` <= {`lo[14:0]`, 1}.
  - Otherwise: `hi` <= `alu_a`; `lo` <= {`lo[14:0]`, 0}.
- **RUN exit:** `cnt` increments each step. The step taken at `cnt` == 15 is the last; the FSM then goes to DONE.
- **DONE:**
  - `done` = 1 for exactly one cycle; the FSM then returns to IDLE.
  - `start` is ignored in DONE.
- **Result outputs:**
  - `res_hi`/`res_lo` = `hi`/`lo`.
  - Held stable from DONE through IDLE until the next accepted `start`.
  - They change during RUN, so they are not valid then.
- **ALU drive outside RUN:** `alu_a`, `alu_b`, `alu_s`, `alu_cin` = 0. All ALU-side outputs are combinational from registered state only; `alu_result`/`alu_c` never feed back into outputs combinationally.
- **`start` during RUN/DONE:** ignored; operands are not re-sampled.
- **Reset (asynchronous, any state, including mid-RUN):**
  - FSM returns to IDLE.
  - All registers and all outputs go to 0: `busy`, `done`, `dz`, `res_*`, `alu_*`, `alu_own`.
  - The aborted operation produces no `done`.

## Timing
- **Normal operation:** `start` sampled at edge E0. RUN is active for the 16 cycles after E0 (`busy` = `alu_own` = 1). Edge E16 completes the final step. `done` = 1 during the cycle after E16; IDLE follows at E17.
- **Divide-by-zero:** `done` = 1 during the cycle after E0, with `busy` never asserted.
- **Back-to-back:** the earliest next `start` is sampled at E17 (first IDLE cycle).
- **Throughput:** one operation per 17 cycles.
- **ALU path:** the ALU is combinational, so each step's `alu_result`/`alu_c` is captured at the same edge that ends the step.

## Test plan
- **Multiply:** `op` = 0, `opa` = 0x1234, `opb` = 0x5678 → `done` in the 17th cycle after the start edge; `res_hi` = 0x0626, `res_lo` = 0x0060, `dz` = 0; `busy` high exactly 16 cycles.
- **Multiply, full-range:** `op` = 0, 0xFFFF × 0xFFFF → 0xFFFE / 0x0001. Also 0x0003 × 0x0005: first RUN cycle shows `alu_s` = 00, `alu_b` = 0x0005, `alu_a` = 0; result 0x0000 / 0x000F.
- **Divide:**
  - `op` = 1, 1000 / 7 (0x03E8 / 0x0007) → `res_lo` = 0x008E, `res_hi` = 0x0006; `alu_s` = 10 throughout RUN.
  - 0xFFFF / 0x0001 → 0xFFFF rem 0.
  - 0x0005 / 0x8001 → q 0, r 5.
- **Divide by zero:** `op` = 1, `opa` = 0x1234, `opb` = 0 → `done` and `dz` = 1 one cycle after the start edge; `res_hi` = 0x1234, `res_lo` = 0xFFFF; `busy` never high; next op clears `dz`.
- **Start ignored while busy:** pulse `start` with new operands at RUN cycle 5 → original result unchanged, single `done`.
- **Reset mid-operation:** assert `rst_n` = 0 asynchronously at RUN cycle 8 → all outputs 0 immediately, no `done`; a fresh 3 × 5 then completes normally.
